// File: rtl/Default_pkg.sv
// Bus-width defaults shared by the TL-UL fabric.
package Default_pkg;
  localparam int TL_AW   = 32;
  localparam int TL_DW   = 32;
  localparam int TL_DBW  = TL_DW / 8;
  localparam int TL_SZW  = 2;
  localparam int TL_SRCW = 8;
endpackage

// File: rtl/TileLinkUL_pkg.sv
// TL-UL opcodes, channel structs and the adapter's response-entry type.
package TileLinkUL_pkg;
  import Default_pkg::*;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic                a_valid;
    tl_a_op_e            a_opcode;
    logic [2:0]          a_param;
    logic [TL_SZW-1:0]   a_size;
    logic [TL_SRCW-1:0]  a_source;
    logic [TL_AW-1:0]    a_address;
    logic [TL_DBW-1:0]   a_mask;
    logic [TL_DW-1:0]    a_data;
    logic                d_ready;
  } tl_m2s_t;

  typedef struct packed {
    logic                d_valid;
    tl_d_op_e            d_opcode;
    logic [2:0]          d_param;
    logic [TL_SZW-1:0]   d_size;
    logic [TL_SRCW-1:0]  d_source;
    logic                d_sink;
    logic [TL_DW-1:0]    d_data;
    logic                d_error;
    logic                a_ready;
  } tl_s2m_t;

  // Everything a D beat needs except the read data, which arrives a cycle later.
  typedef struct packed {
    tl_d_op_e            d_opcode;
    logic [TL_SZW-1:0]   d_size;
    logic [TL_SRCW-1:0]  d_source;
    logic                d_error;
    logic                is_read;
  } rsp_entry_t;
endpackage

// File: rtl/tl_ul_rsp_fifo.sv
// In-order response FIFO with an arbitrary (non power-of-two) depth and a
// separate late-write port that fills an entry's data slot after the push.
module tl_ul_rsp_fifo #(
  parameter int  Depth = 2,
  parameter type entry_t = logic,
  parameter int  DataW = 32,
  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int CntW = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  entry_t           push_entry_i,
  input  logic             pop_i,
  input  logic             data_we_i,
  input  logic [PtrW-1:0]  data_idx_i,
  input  logic [DataW-1:0] data_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [PtrW-1:0]  wptr_o,
  output logic [PtrW-1:0]  rptr_o,
  output entry_t           head_entry_o,
  output logic [DataW-1:0] head_data_o
);

  entry_t           entry_q [Depth];
  logic [DataW-1:0] data_q  [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wptr_q <= ptr_inc(wptr_q);
      if (pop_i)  rptr_q <= ptr_inc(rptr_q);
      if (push_i && !pop_i)      count_q <= count_q + 1'b1;
      else if (!push_i && pop_i) count_q <= count_q - 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; count_q gates every read of it,
  // so stale contents are never observable and the arrays stay plain flops/RAM.
  always_ff @(posedge clk_i) begin
    if (push_i)    entry_q[wptr_q]    <= push_entry_i;
    if (data_we_i) data_q[data_idx_i] <= data_i;
  end

  assign full_o       = (count_q == CntW'(Depth));
  assign empty_o      = (count_q == '0);
  assign wptr_o       = wptr_q;
  assign rptr_o       = rptr_q;
  assign head_entry_o = entry_q[rptr_q];
  assign head_data_o  = data_q[rptr_q];

endmodule

// File: rtl/tl_ul_sram_adapter.sv
// TL-UL slave driving a one-cycle-latency single-port SRAM, one beat per cycle.
// Request checking is compiled in with `define TL_SRAM_ADAPTER_ERRCHK_EN.
module tl_ul_sram_adapter
  import Default_pkg::*;
  import TileLinkUL_pkg::*;
#(
  parameter int SramAw      = 10,
  parameter int Outstanding = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  tl_m2s_t           tl_i,
  output tl_s2m_t           tl_o,
  output logic              sram_req_o,
  output logic              sram_we_o,
  output logic [SramAw-1:0] sram_addr_o,
  output logic [TL_DW-1:0]  sram_wdata_o,
  output logic [TL_DBW-1:0] sram_wmask_o,
  input  logic [TL_DW-1:0]  sram_rdata_i
);

  localparam int OffW = $clog2(TL_DBW);
  localparam int PtrW = (Outstanding > 1) ? $clog2(Outstanding) : 1;

  logic             a_ready, handshake, is_get, is_put, req_err;
  logic             fifo_full, fifo_empty, pop;
  logic [PtrW-1:0]  wptr, rptr;
  rsp_entry_t       push_entry, head_entry;
  logic [TL_DW-1:0] head_data;
  logic             rd_pending_q;
  logic [PtrW-1:0]  rd_idx_q;
  logic             unused_a_param;

  assign is_get  = (tl_i.a_opcode == Get);
  assign is_put  = (tl_i.a_opcode == PutFullData) || (tl_i.a_opcode == PutPartialData);
  assign a_ready = !fifo_full;
  assign handshake = tl_i.a_valid && a_ready;
  assign unused_a_param = ^tl_i.a_param;

`ifdef TL_SRAM_ADAPTER_ERRCHK_EN
  logic [TL_AW-1:0] align_mask;
  assign align_mask = (TL_AW'(1) << tl_i.a_size) - TL_AW'(1);
  assign req_err = !(is_get || is_put)
                || (|tl_i.a_address[TL_AW-1:SramAw+OffW])
                || (|(tl_i.a_address & align_mask))
                || (is_put && (tl_i.a_mask == '0));
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^tl_i.a_address[TL_AW-1:SramAw+OffW];
  assign req_err = 1'b0;
`endif

  assign sram_req_o   = handshake && !req_err;
  assign sram_we_o    = !is_get;
  assign sram_addr_o  = tl_i.a_address[SramAw+OffW-1:OffW];
  assign sram_wdata_o = tl_i.a_data;
  assign sram_wmask_o = tl_i.a_mask;

  always_comb begin
    push_entry          = '0;
    push_entry.d_opcode = is_put ? AccessAck : AccessAckData;
    push_entry.d_size   = tl_i.a_size;
    push_entry.d_source = tl_i.a_source;
    push_entry.d_error  = req_err;
    push_entry.is_read  = is_get && !req_err;
  end

  // Remember which slot the read issued this cycle belongs to; its data
  // arrives next cycle. Reset drops it, so an in-flight read is never captured.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_pending_q <= 1'b0;
      rd_idx_q     <= '0;
    end else begin
      rd_pending_q <= sram_req_o && !sram_we_o;
      rd_idx_q     <= wptr;
    end
  end

  tl_ul_rsp_fifo #(
    .Depth   (Outstanding),
    .entry_t (rsp_entry_t),
    .DataW   (TL_DW)
  ) u_rsp_fifo (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .push_i       (handshake),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .data_we_i    (rd_pending_q),
    .data_idx_i   (rd_idx_q),
    .data_i       (sram_rdata_i),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .wptr_o       (wptr),
    .rptr_o       (rptr),
    .head_entry_o (head_entry),
    .head_data_o  (head_data)
  );

  assign pop = !fifo_empty && tl_i.d_ready;

  always_comb begin
    tl_o         = '0;
    tl_o.a_ready = a_ready;
    tl_o.d_valid = !fifo_empty;
    if (!fifo_empty) begin
      tl_o.d_opcode = head_entry.d_opcode;
      tl_o.d_size   = head_entry.d_size;
      tl_o.d_source = head_entry.d_source;
      tl_o.d_error  = head_entry.d_error;
      if (head_entry.is_read) begin
        // Head read whose data is still on the SRAM bus: forward it directly.
        tl_o.d_data = (rd_pending_q && (rd_idx_q == rptr)) ? sram_rdata_i : head_data;
      end
    end
  end

endmodule

// File: tb/tb_tl_ul_sram_adapter.sv
// Self-checking bench: SRAM model, queue scoreboard, randomized and directed traffic.
module tb_tl_ul_sram_adapter;
  import Default_pkg::*;
  import TileLinkUL_pkg::*;

  localparam int SRAM_AW = 10;
  localparam int OUTST   = 2;
  localparam int ADDR_HI = SRAM_AW + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_valid = 1'b0;
  logic [2:0]  a_op = 3'd4;
  logic [1:0]  a_size = 2'd2;
  logic [7:0]  a_src = 8'd0;
  logic [31:0] a_addr = 32'd0;
  logic [3:0]  a_mask = 4'd0;
  logic [31:0] a_data = 32'd0;
  logic        d_ready = 1'b0;

  tl_m2s_t tl_i;
  tl_s2m_t tl_o;
  logic              sram_req, sram_we;
  logic [SRAM_AW-1:0] sram_addr;
  logic [31:0]       sram_wdata;
  logic [3:0]        sram_wmask;
  logic [31:0]       sram_rdata = 32'd0;

  always_comb begin
    tl_i           = '0;
    tl_i.a_valid   = a_valid;
    tl_i.a_opcode  = tl_a_op_e'(a_op);
    tl_i.a_size    = a_size;
    tl_i.a_source  = a_src;
    tl_i.a_address = a_addr;
    tl_i.a_mask    = a_mask;
    tl_i.a_data    = a_data;
    tl_i.d_ready   = d_ready;
  end

  tl_ul_sram_adapter #(.SramAw(SRAM_AW), .Outstanding(OUTST)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .tl_i         (tl_i),
    .tl_o         (tl_o),
    .sram_req_o   (sram_req),
    .sram_we_o    (sram_we),
    .sram_addr_o  (sram_addr),
    .sram_wdata_o (sram_wdata),
    .sram_wmask_o (sram_wmask),
    .sram_rdata_i (sram_rdata)
  );

  // SRAM macro model: byte-masked write, read data one cycle after the strobe.
  logic [31:0] sram_mem [1024];
  always @(posedge clk) begin
    if (sram_req) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++)
          if (sram_wmask[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= sram_mem[sram_addr];
      end
    end
  end

  int cyc = 0;
  int strobe_cnt = 0;
  always @(posedge clk) begin
    cyc++;
    if (rst_n && sram_req) strobe_cnt++;
  end

  int n_checks = 0;
  int n_err = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: word array updated in accept order plus the expected D beats.
  typedef struct {
    logic [2:0]  op;
    logic [1:0]  size;
    logic [7:0]  src;
    logic        err;
    logic [31:0] data;
  } exp_t;
  exp_t        sb[$];
  logic [31:0] ref_mem [1024];

  function automatic logic model_err(input logic [2:0] op, input logic [31:0] addr,
                                     input logic [1:0] size, input logic [3:0] mask);
`ifdef TL_SRAM_ADAPTER_ERRCHK_EN
    logic is_put;
    is_put = (op == 3'd0) || (op == 3'd1);
    return !(is_put || op == 3'd4) || (addr >> ADDR_HI) != 0
        || (addr % (32'd1 << size)) != 0 || (is_put && mask == 4'd0);
`else
    return (op === 3'bx) && (addr === 32'bx) && (size === 2'bx) && (mask === 4'bx);
`endif
  endfunction

  task automatic model_accept(input logic [2:0] op, input logic [31:0] addr, input logic [1:0] size,
                              input logic [3:0] mask, input logic [31:0] data, input logic [7:0] src);
    exp_t e;
    int   w;
    w      = int'(addr[ADDR_HI-1:2]);
    e.err  = model_err(op, addr, size, mask);
    e.size = size;
    e.src  = src;
    e.data = 32'd0;
    if (op == 3'd0 || op == 3'd1) begin
      e.op = 3'd0;
      if (!e.err)
        for (int b = 0; b < 4; b++) if (mask[b]) ref_mem[w][8*b +: 8] = data[8*b +: 8];
    end else begin
      e.op = 3'd1;
      if (!e.err) e.data = ref_mem[w];
    end
    sb.push_back(e);
  endtask

  int accept_cnt = 0;
  int acc_cyc = 0;

  task automatic send(input logic [2:0] op, input logic [31:0] addr, input logic [1:0] size,
                      input logic [3:0] mask, input logic [31:0] data, input logic [7:0] src);
    logic ok;
    int   budget;
    budget = 0;
    @(negedge clk);
    a_valid = 1'b1; a_op = op; a_addr = addr; a_size = size;
    a_mask = mask; a_data = data; a_src = src;
    forever begin
      ok = tl_o.a_ready;
      acc_cyc = cyc;
      @(posedge clk);
      if (ok) break;
      budget++;
      if (budget > 100) begin
        check("accept_timeout", 64'd0, 64'd1);
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      model_accept(op, addr, size, mask, data, src);
      accept_cnt++;
    end
    #1 a_valid = 1'b0;
  endtask

  // d_ready policy: 0 = always ready, 1 = stalled, 2 = random.
  int dr_mode = 0;
  logic [31:0] last_d_data = 32'd0;
  logic        last_d_error = 1'b0;

  initial forever begin
    int n;
    exp_t e;
    @(negedge clk);
    case (dr_mode)
      0:       d_ready = 1'b1;
      1:       d_ready = 1'b0;
      default: d_ready = 1'($urandom_range(0, 1));
    endcase
    if (rst_n) begin
      n = sb.size();
      check("a_ready", 64'(tl_o.a_ready), 64'(n < OUTST));
      check("d_valid", 64'(tl_o.d_valid), 64'(n != 0));
      if (tl_o.d_valid && n != 0) begin
        e = sb[0];
        check("d_hdr", {tl_o.d_opcode, tl_o.d_size, tl_o.d_source, tl_o.d_error},
              {e.op, e.size, e.src, e.err});
        check("d_data", 64'(tl_o.d_data), 64'(e.data));
        if (d_ready) begin
          last_d_data  = tl_o.d_data;
          last_d_error = tl_o.d_error;
          void'(sb.pop_front());
        end
      end
      #2;
      if (rst_n) begin
        logic exp_req;
        exp_req = a_valid && (n < OUTST) && !model_err(a_op, a_addr, a_size, a_mask);
        check("sram_req", 64'(sram_req), 64'(exp_req));
        if (exp_req)
          check("sram_cmd", {sram_we, sram_addr, sram_wdata, sram_wmask},
                {(a_op != 3'd4), a_addr[ADDR_HI-1:2], a_data, a_mask});
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    check("drain", 64'(sb.size()), 64'd0);
    @(posedge clk);
  endtask

  initial begin
    int first_cyc, acc0, st0;
    logic [2:0] op;
    logic [31:0] addr;
    for (int i = 0; i < 1024; i++) begin
      logic [31:0] v;
      v = $urandom;
      sram_mem[i] = v;
      ref_mem[i]  = v;
    end
    dr_mode = 0;
    #12;
    check("rst_a_ready", 64'(tl_o.a_ready), 64'd1);
    check("rst_d_valid", 64'(tl_o.d_valid), 64'd0);
    check("rst_d_data", 64'(tl_o.d_data), 64'd0);
    check("rst_d_error", 64'(tl_o.d_error), 64'd0);
    check("rst_sram_req", 64'(sram_req), 64'd0);
    @(negedge clk) #3 rst_n = 1'b1;

    // Single Get of word 4.
    send(3'd4, 32'h10, 2'd2, 4'hf, 32'd0, 8'd3);
    drain();
    check("get_word4", 64'(last_d_data), 64'(ref_mem[4]));

    // Partial write merge.
    sram_mem[8] = 32'h11223344;
    ref_mem[8]  = 32'h11223344;
    send(3'd1, 32'h20, 2'd2, 4'b0101, 32'hAABBCCDD, 8'd1);
    send(3'd4, 32'h20, 2'd2, 4'hf, 32'd0, 8'd5);
    drain();
    check("partial_merge", 64'(last_d_data), 64'h11BB33DD);

    // 16 back-to-back Gets.
    for (int i = 0; i < 16; i++) begin
      send(3'd4, 32'(($urandom_range(0, 1023)) << 2), 2'd2, 4'hf, 32'd0, 8'(i));
      if (i == 0) first_cyc = acc_cyc;
    end
    check("b2b_cycles", 64'(acc_cyc - first_cyc), 64'd15);
    drain();

    // Backpressure: responses stalled under continuous requests.
    dr_mode = 1;
    acc0 = accept_cnt;
    st0  = strobe_cnt;
    fork
      begin
        send(3'd4, 32'h40, 2'd2, 4'hf, 32'd0, 8'd7);
        send(3'd4, 32'h44, 2'd2, 4'hf, 32'd0, 8'd8);
        send(3'd4, 32'h48, 2'd2, 4'hf, 32'd0, 8'd9);
      end
    join_none
    repeat (6) @(negedge clk);
    check("bp_accepts", 64'(accept_cnt - acc0), 64'd2);
    check("bp_strobes", 64'(strobe_cnt - st0), 64'd2);
    dr_mode = 0;
    for (int i = 0; i < 100 && accept_cnt != acc0 + 3; i++) @(negedge clk);
    check("bp_done", 64'(accept_cnt - acc0), 64'd3);
    drain();

`ifdef TL_SRAM_ADAPTER_ERRCHK_EN
    st0 = strobe_cnt;
    send(3'd4, 32'h1002, 2'd2, 4'hf, 32'd0, 8'd2);
    drain();
    check("misalign_err", 64'(last_d_error), 64'd1);
    check("misalign_nostrobe", 64'(strobe_cnt - st0), 64'd0);
    send(3'd4, 32'h10000, 2'd2, 4'hf, 32'd0, 8'd2);
    drain();
    check("oor_err", 64'(last_d_error), 64'd1);
    check("oor_data", 64'(last_d_data), 64'd0);
`endif

    // Randomized traffic with random response backpressure.
    dr_mode = 2;
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 2))
        0:       op = 3'd4;
        1:       op = 3'd0;
        default: op = 3'd1;
      endcase
`ifdef TL_SRAM_ADAPTER_ERRCHK_EN
      if ($urandom_range(0, 15) == 0) op = 3'($urandom_range(2, 3));
`endif
      addr = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 4095));
      send(op, addr, 2'($urandom_range(0, 2)), 4'($urandom), $urandom, 8'($urandom));
    end
    dr_mode = 0;
    drain();

    // Reset with two responses pending.
    dr_mode = 1;
    send(3'd4, 32'h30, 2'd2, 4'hf, 32'd0, 8'd10);
    send(3'd0, 32'h34, 2'd2, 4'hf, 32'h1234, 8'd11);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rstmid_d_valid", 64'(tl_o.d_valid), 64'd0);
    sb.delete();
    @(negedge clk) #3 rst_n = 1'b1;
    @(negedge clk) #1;
    check("rstmid_a_ready", 64'(tl_o.a_ready), 64'd1);
    dr_mode = 0;
    repeat (10) @(negedge clk);
    check("rstmid_no_stale", 64'(tl_o.d_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
